// File: rtl/bch_run_sequencer.sv
// Command-driven scheduler for the BCH test chain: decodes UART command frames,
// sequences encode/noise/errgen/decode with start/done handshakes and timeouts, and reports one byte.
module bch_run_sequencer #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int MAX_ERRORS     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [47:0] cmd_frame,
   output logic [3:0]  stage_start,
   input  logic [3:0]  stage_done,
   output logic [7:0]  cfg_message,
   output logic [7:0]  cfg_num_errors,
   output logic        busy,
   output logic        tx_valid,
   output logic [7:0]  tx_byte,
   input  logic        tx_ready,
   output logic [7:0]  led_status
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ENCODE = 3'd1;
   localparam logic [2:0] S_NOISE  = 3'd2;
   localparam logic [2:0] S_ERRGEN = 3'd3;
   localparam logic [2:0] S_DECODE = 3'd4;
   localparam logic [2:0] S_REPORT = 3'd5;
   localparam logic [2:0] S_FAIL   = 3'd6;

   localparam logic [7:0] OP_RUN    = 8'h01;
   localparam logic [7:0] OP_ABORT  = 8'h02;
   localparam logic [7:0] OP_STATUS = 8'h03;

   localparam logic [7:0] RES_OK       = 8'h00;
   localparam logic [7:0] RES_BAD_OP   = 8'hE1;
   localparam logic [7:0] RES_TOO_MANY = 8'hE2;
   localparam logic [7:0] RES_NO_STAGE = 8'hE3;
   localparam logic [7:0] RES_ABORT    = 8'hEA;

   // First enabled stage at or after index 'from'; decode rides on the ENC flag.
   function automatic logic [2:0] next_stage(input logic [2:0] flags, input logic [2:0] from);
      logic [3:0] en;
      logic [2:0] nxt;
      en  = {flags[0], flags[2], flags[1], flags[0]};
      nxt = S_REPORT;
      for (int i = 3; i >= 0; i--) begin
         if ((i >= int'(from)) && en[i]) begin
            nxt = 3'(i + 1);
         end
      end
      return nxt;
   endfunction

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    flags_q, flags_d;
   logic [7:0]    cfg_msg_q, cfg_msg_d;
   logic [7:0]    cfg_nerr_q, cfg_nerr_d;
   logic [7:0]    result_q, result_d;
   logic [2:0]    err_q, err_d;
   logic          ok_q, ok_d;
   logic          pend_valid_q, pend_valid_d;
   logic [7:0]    pend_byte_q, pend_byte_d;
   logic          pend_lock_q, pend_lock_d;

   logic [7:0] opcode;
   logic [2:0] flags_f;
   logic [7:0] n_err_f;
   logic [7:0] msg_f;
   logic       is_run, is_abort, is_status, is_bad;
   logic       in_stage;
   logic [1:0] stage_idx;
   logic [2:0] stage_num;
   logic       done_act;
   logic       cnt_max;
   logic       pend_offer;
   logic [2:0] following;
   logic [7:0] status_byte;
   logic       unused_frame_bits;

   assign opcode    = cmd_frame[47:40];
   assign flags_f   = cmd_frame[34:32];
   assign n_err_f   = cmd_frame[31:24];
   assign msg_f     = cmd_frame[23:16];
   assign unused_frame_bits = ^{cmd_frame[39:35], cmd_frame[15:0]};

   assign is_run    = cmd_valid && (opcode == OP_RUN);
   assign is_abort  = cmd_valid && (opcode == OP_ABORT);
   assign is_status = cmd_valid && (opcode == OP_STATUS);
   assign is_bad    = cmd_valid && !(opcode == OP_RUN || opcode == OP_ABORT || opcode == OP_STATUS);

   assign in_stage   = (state_q >= S_ENCODE) && (state_q <= S_DECODE);
   assign stage_idx  = 2'(state_q - 3'd1);
   assign stage_num  = {1'b0, stage_idx} + 3'd1;
   assign done_act   = stage_done[stage_idx];
   assign cnt_max    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign following  = next_stage(flags_q, stage_num);
   assign status_byte = {(state_q != S_IDLE), state_q, err_q, ok_q};

   // A queued status/bad-opcode byte goes out only from IDLE, but once offered it
   // stays on the bus until taken, even if a run starts underneath it.
   assign pend_offer = pend_valid_q && ((state_q == S_IDLE) || pend_lock_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         flags_q      <= '0;
         cfg_msg_q    <= '0;
         cfg_nerr_q   <= '0;
         result_q     <= '0;
         err_q        <= '0;
         ok_q         <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_byte_q  <= '0;
         pend_lock_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flags_q      <= flags_d;
         cfg_msg_q    <= cfg_msg_d;
         cfg_nerr_q   <= cfg_nerr_d;
         result_q     <= result_d;
         err_q        <= err_d;
         ok_q         <= ok_d;
         pend_valid_q <= pend_valid_d;
         pend_byte_q  <= pend_byte_d;
         pend_lock_q  <= pend_lock_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      flags_d      = flags_q;
      cfg_msg_d    = cfg_msg_q;
      cfg_nerr_d   = cfg_nerr_q;
      result_d     = result_q;
      err_d        = err_q;
      ok_d         = ok_q;
      pend_valid_d = pend_valid_q;
      pend_byte_d  = pend_byte_q;
      pend_lock_d  = pend_offer && !tx_ready;

      case (state_q)
         S_IDLE: begin
            if (is_run) begin
               if (flags_f[2] && (n_err_f > 8'(MAX_ERRORS))) begin
                  state_d  = S_REPORT;
                  result_d = RES_TOO_MANY;
               end else if (flags_f == 3'b000) begin
                  state_d  = S_REPORT;
                  result_d = RES_NO_STAGE;
               end else begin
                  state_d    = next_stage(flags_f, 3'd0);
                  flags_d    = flags_f;
                  cfg_msg_d  = msg_f;
                  cfg_nerr_d = n_err_f;
                  err_d      = 3'd0;
               end
            end else if (is_abort) begin
               state_d  = S_REPORT;
               result_d = RES_ABORT;
            end
         end
         S_ENCODE, S_NOISE, S_ERRGEN, S_DECODE: begin
            // Abort beats done, done beats timeout.
            if (is_abort) begin
               state_d  = S_REPORT;
               result_d = RES_ABORT;
            end else if (done_act) begin
               state_d = following;
               if (following == S_REPORT) begin
                  result_d = RES_OK;
               end
            end else if (cnt_max) begin
               state_d  = S_FAIL;
               err_d    = stage_num;
               result_d = {6'b1111_00, stage_idx};
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FAIL: begin
            state_d = S_REPORT;
         end
         S_REPORT: begin
            if (!pend_offer && tx_ready) begin
               state_d = S_IDLE;
               ok_d    = (result_q == RES_OK);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (pend_offer && tx_ready) begin
         pend_valid_d = 1'b0;
      end
      if (!pend_valid_q) begin
         if (is_status && (state_q != S_REPORT)) begin
            pend_valid_d = 1'b1;
            pend_byte_d  = status_byte;
         end else if (is_bad) begin
            pend_valid_d = 1'b1;
            pend_byte_d  = RES_BAD_OP;
         end
      end
   end

   always_comb begin
      stage_start = 4'b0000;
      if (in_stage && (cnt_q == '0) && !rst) begin
         stage_start[stage_idx] = 1'b1;
      end
      busy           = (state_q != S_IDLE);
      tx_valid       = pend_offer || (state_q == S_REPORT);
      tx_byte        = pend_offer ? pend_byte_q :
                       ((state_q == S_REPORT) ? result_q : 8'h00);
      cfg_message    = cfg_msg_q;
      cfg_num_errors = cfg_nerr_q;
      led_status     = {state_q, err_q, ok_q, (state_q != S_IDLE)};
   end

endmodule

// File: tb/tb_bch_run_sequencer.sv
// Directed bench for bch_run_sequencer: result bytes are scoreboarded through a queue,
// start pulses are logged by a monitor and checked against each scenario.
module tb_bch_run_sequencer;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [47:0] cmd_frame;
   logic [3:0]  stage_start;
   logic [3:0]  stage_done = 4'b0000;
   logic [7:0]  cfg_message;
   logic [7:0]  cfg_num_errors;
   logic        busy;
   logic        tx_valid;
   logic [7:0]  tx_byte;
   logic        tx_ready;
   logic [7:0]  led_status;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int tx_cyc = 0;
   logic [7:0] exp_q[$];
   logic [3:0] start_log[$];
   int         start_cyc[$];
   int         dly[4] = '{5, 5, 5, 5};
   int         cd[4]  = '{0, 0, 0, 0};

   bch_run_sequencer #(.TIMEOUT_CYCLES(T), .MAX_ERRORS(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_frame      (cmd_frame),
      .stage_start    (stage_start),
      .stage_done     (stage_done),
      .cfg_message    (cfg_message),
      .cfg_num_errors (cfg_num_errors),
      .busy           (busy),
      .tx_valid       (tx_valid),
      .tx_byte        (tx_byte),
      .tx_ready       (tx_ready),
      .led_status     (led_status)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stage models: done pulses dly[b] cycles after the start pulse; dly 0 never answers.
   always @(negedge clk) begin
      for (int b = 0; b < 4; b++) begin
         stage_done[b] = 1'b0;
         if (cd[b] > 0) begin
            cd[b]--;
            if (cd[b] == 0) stage_done[b] = 1'b1;
         end
         if (stage_start[b] && dly[b] > 0) cd[b] = dly[b];
      end
   end

   always @(negedge clk) begin
      if (stage_start != 4'b0000) begin
         start_log.push_back(stage_start);
         start_cyc.push_back(cyc);
      end
      if (tx_valid && tx_ready) begin
         tx_cyc = cyc;
         check("tx_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("tx_byte", 32'(tx_byte), 32'(e));
            $display("tx byte %02h (expected %02h) at cycle %0d", tx_byte, e, cyc);
         end
      end
   end

   function automatic logic [31:0] pack_log();
      logic [31:0] r;
      r = '0;
      foreach (start_log[i]) r = {r[27:0], start_log[i]};
      return r;
   endfunction

   task automatic clear_log();
      start_log.delete();
      start_cyc.delete();
   endtask

   task automatic send(input logic [7:0] op, input logic [7:0] fl, input logic [7:0] ne, input logic [7:0] msg);
      cmd_frame = {op, fl, ne, msg, 16'h0000};
      cmd_valid = 1'b1;
      $display("cmd op=%02h flags=%02h n_err=%0d msg=%02h at cycle %0d", op, fl, ne, msg, cyc);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_frame = '0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((busy || tx_valid || exp_q.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(n < 200), 32'd1);
   endtask

   task automatic wait_starts(input string tag, input int count);
      int n;
      n = 0;
      while (start_log.size() < count && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(n < 100), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_frame = '0;
      tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_start", 32'(stage_start), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_txv", 32'(tx_valid), 32'h0);
      check("rst_txb", 32'(tx_byte), 32'h0);
      check("rst_led", 32'(led_status), 32'h0);
      check("rst_cfg", 32'({cfg_message, cfg_num_errors}), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full chain
      clear_log();
      exp_q.push_back(8'h00);
      send(8'h01, 8'h07, 8'd3, 8'hAA);
      wait_idle("t1_idle");
      check("t1_starts", pack_log(), 32'h1248);
      check("t1_nstarts", 32'(start_log.size()), 32'd4);
      check("t1_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd6);
      check("t1_msg", 32'(cfg_message), 32'hAA);
      check("t1_nerr", 32'(cfg_num_errors), 32'd3);
      check("t1_ok", 32'(led_status[1]), 32'd1);

      // Error generator only
      clear_log();
      exp_q.push_back(8'h00);
      send(8'h01, 8'h04, 8'd2, 8'h55);
      wait_idle("t2_idle");
      check("t2_starts", pack_log(), 32'h4);
      check("t2_nerr", 32'(cfg_num_errors), 32'd2);
      check("t2_ok", 32'(led_status[1]), 32'd1);

      // Too many errors: rejected, cfg untouched
      clear_log();
      exp_q.push_back(8'hE2);
      send(8'h01, 8'h05, 8'd5, 8'h12);
      wait_idle("t3_idle");
      check("t3_nstarts", 32'(start_log.size()), 32'd0);
      check("t3_cfg", 32'({cfg_message, cfg_num_errors}), 32'h5502);
      check("t3_ok", 32'(led_status[1]), 32'd0);

      // No stage enabled (upper flag bits ignored)
      clear_log();
      exp_q.push_back(8'hE3);
      send(8'h01, 8'hF8, 8'd1, 8'h34);
      wait_idle("t3b_idle");
      check("t3b_nstarts", 32'(start_log.size()), 32'd0);

      // n_err exactly MAX_ERRORS is accepted
      clear_log();
      exp_q.push_back(8'h00);
      send(8'h01, 8'h04, 8'd4, 8'h21);
      wait_idle("t3c_idle");
      check("t3c_starts", pack_log(), 32'h4);
      check("t3c_nerr", 32'(cfg_num_errors), 32'd4);

      // Noise stage never answers -> timeout
      clear_log();
      dly[1] = 0;
      exp_q.push_back(8'hF1);
      send(8'h01, 8'h03, 8'd1, 8'h66);
      wait_idle("t4_idle");
      check("t4_starts", pack_log(), 32'h12);
      check("t4_latency", 32'(tx_cyc - start_cyc[1]), 32'(T + 1));
      check("t4_err", 32'(led_status[4:2]), 32'd2);
      check("t4_ok", 32'(led_status[1]), 32'd0);
      dly[1] = 5;

      // Status, bad opcode, abort from idle
      exp_q.push_back(8'h04);
      send(8'h03, 8'h00, 8'd0, 8'h00);
      wait_idle("st_idle");
      exp_q.push_back(8'hE1);
      send(8'h7F, 8'h00, 8'd0, 8'h00);
      wait_idle("bad_idle");
      exp_q.push_back(8'hEA);
      send(8'h02, 8'h00, 8'd0, 8'h00);
      wait_idle("ab_idle");
      check("ab_ok", 32'(led_status[1]), 32'd0);

      // Abort during ERRGEN with a stalled transmitter
      clear_log();
      tx_ready = 1'b0;
      send(8'h01, 8'h07, 8'd1, 8'h77);
      wait_starts("t5_errgen", 3);
      exp_q.push_back(8'hEA);
      send(8'h02, 8'h00, 8'd0, 8'h00);
      begin
         int n;
         n = 0;
         while (!tx_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         check("t5_txv_seen", 32'(n < 50), 32'd1);
      end
      check("t5_state", 32'(led_status[7:5]), 32'd5);
      for (int k = 0; k < 10; k++) begin
         check("t5_hold_v", 32'(tx_valid), 32'd1);
         check("t5_hold_b", 32'(tx_byte), 32'hEA);
         @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      check("t5_busy", 32'(busy), 32'd0);
      wait_idle("t5_idle");
      check("t5_starts", pack_log(), 32'h124);

      // Reset during DECODE
      clear_log();
      send(8'h01, 8'h07, 8'd1, 8'h99);
      wait_starts("t6_decode", 4);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t6_start", 32'(stage_start), 32'h0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_txv", 32'(tx_valid), 32'd0);
      check("t6_led", 32'(led_status), 32'h0);
      check("t6_cfg", 32'({cfg_message, cfg_num_errors}), 32'h0);
      repeat (10) @(posedge clk);
      #1;
      check("t6_busy_late", 32'(busy), 32'd0);
      check("t6_nstarts", 32'(start_log.size()), 32'd4);
      check("t6_txv_late", 32'(tx_valid), 32'd0);
      check("t6_queue", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "watchdog");
   end

endmodule
